// File: rtl/imm_gen_pipe_if.sv
// Bundle-level handshake between decode, the immediate generator and rename.
// master drives bundles in and accepts results; slave is the generator side.
interface imm_gen_pipe_if #(
   parameter int LANES = 2,
   parameter int XLEN  = 32,
   parameter int IMM_W = 25
);
   logic                     in_valid;
   logic                     in_ready;
   logic [LANES-1:0]         in_lane_en;
   logic [LANES*IMM_W-1:0]   imm;
   logic [LANES*3-1:0]       imm_src;
   logic                     out_valid;
   logic                     out_ready;
   logic [LANES-1:0]         out_lane_en;
   logic [LANES*XLEN-1:0]    imm_ext;
   logic [LANES-1:0]         out_illegal;

   modport master (
      output in_valid, in_lane_en, imm, imm_src, out_ready,
      input  in_ready, out_valid, out_lane_en, imm_ext, out_illegal
   );

   modport slave (
      input  in_valid, in_lane_en, imm, imm_src, out_ready,
      output in_ready, out_valid, out_lane_en, imm_ext, out_illegal
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// Multi-lane immediate generator: combinational per-lane decode feeding a
// main output register backed by one skid register for rename backpressure.
module imm_gen_pipe #(
   parameter int LANES = 2,
   parameter int XLEN  = 32,
   parameter int IMM_W = 25
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   imm_gen_pipe_if.slave bus
);
   localparam int OUT_W = LANES * XLEN;

   // Returns {illegal, immediate}; f holds instruction bits [31:7].
   function automatic logic [XLEN:0] decode_lane(
      input logic [IMM_W-1:0] f,
      input logic [2:0]       src,
      input logic             en
   );
      logic signed [31:0]     r;
      logic signed [XLEN-1:0] x;
      logic                   ill;
      r   = '0;
      ill = 1'b0;
      case (src)
         3'b000:  r = {{20{f[24]}}, f[24:13]};
         3'b001:  r = {{20{f[24]}}, f[24:18], f[4:0]};
         3'b010:  r = {{19{f[24]}}, f[24], f[0], f[23:18], f[4:1], 1'b0};
         3'b011:  r = {f[24:5], 12'b0};
         3'b100:  r = {{11{f[24]}}, f[24], f[12:5], f[13], f[23:14], 1'b0};
         default: ill = 1'b1;
      endcase
      x = XLEN'(r);
      if (!en) begin
         x   = '0;
         ill = 1'b0;
      end
      return {ill, x};
   endfunction

   // ---- p0: combinational decode of the presented bundle ----
   logic [OUT_W-1:0] imm_p0;
   logic [LANES-1:0] ill_p0;

   always_comb begin
      imm_p0 = '0;
      ill_p0 = '0;
      for (int k = 0; k < LANES; k++) begin
         {ill_p0[k], imm_p0[k*XLEN +: XLEN]} =
            decode_lane(bus.imm[k*IMM_W +: IMM_W], bus.imm_src[k*3 +: 3], bus.in_lane_en[k]);
      end
   end

   // ---- p1: main register (drives outputs) and skid register ----
   logic             vld_p1;
   logic             skid_vld_p1;
   logic             rdy_p1;
   logic [OUT_W-1:0] main_imm_p1;
   logic [LANES-1:0] main_en_p1;
   logic [LANES-1:0] main_ill_p1;
   logic [OUT_W-1:0] skid_imm_p1;
   logic [LANES-1:0] skid_en_p1;
   logic [LANES-1:0] skid_ill_p1;

   logic in_xfer;
   logic out_xfer;
   logic vld_nxt;
   logic skid_nxt;
   logic load_main_in;
   logic load_main_sk;
   logic load_sk;

   assign in_xfer  = bus.in_valid & rdy_p1 & ~flush & ~reset;
   assign out_xfer = vld_p1 & bus.out_ready;

   // Main refills from skid first so bundle order is never inverted.
   always_comb begin
      vld_nxt      = vld_p1;
      skid_nxt     = skid_vld_p1;
      load_main_in = 1'b0;
      load_main_sk = 1'b0;
      load_sk      = 1'b0;
      if (!vld_p1 || out_xfer) begin
         if (skid_vld_p1) begin
            load_main_sk = 1'b1;
            vld_nxt      = 1'b1;
            skid_nxt     = 1'b0;
         end else if (in_xfer) begin
            load_main_in = 1'b1;
            vld_nxt      = 1'b1;
         end else begin
            vld_nxt      = 1'b0;
         end
      end else if (in_xfer) begin
         load_sk  = 1'b1;
         skid_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
         rdy_p1      <= 1'b1;
         main_imm_p1 <= '0;
         main_en_p1  <= '0;
         main_ill_p1 <= '0;
      end else if (flush) begin
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
         rdy_p1      <= 1'b1;
      end else begin
         vld_p1      <= vld_nxt;
         skid_vld_p1 <= skid_nxt;
         rdy_p1      <= ~skid_nxt;
         if (load_main_sk) begin
            main_imm_p1 <= skid_imm_p1;
            main_en_p1  <= skid_en_p1;
            main_ill_p1 <= skid_ill_p1;
         end else if (load_main_in) begin
            main_imm_p1 <= imm_p0;
            main_en_p1  <= bus.in_lane_en;
            main_ill_p1 <= ill_p0;
         end
      end
   end

   // Skid contents are meaningless while skid_vld_p1 is low, so no reset.
   always_ff @(posedge clk) begin
      if (load_sk) begin
         skid_imm_p1 <= imm_p0;
         skid_en_p1  <= bus.in_lane_en;
         skid_ill_p1 <= ill_p0;
      end
   end

   assign bus.in_ready    = rdy_p1;
   assign bus.out_valid   = vld_p1;
   assign bus.imm_ext     = main_imm_p1;
   assign bus.out_lane_en = main_en_p1;
   assign bus.out_illegal = main_ill_p1;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus,
// checked against constant vectors and a queue-based reference model.
module tb_imm_gen_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, flush, in_valid, out_ready;
   logic [1:0]  lane_en;
   logic [49:0] imm;
   logic [5:0]  src;

   typedef struct packed {
      logic [1:0]   en;
      logic [127:0] x;
      logic [1:0]   ill;
   } bund_t;

   typedef struct {
      logic [1:0]   en;
      logic [49:0]  imm;
      logic [5:0]   src;
      logic [127:0] x;
      logic [1:0]   ill;
   } vec_t;

   int    n_cmp  = 0;
   int    n_fail = 0;
   bit    mon_en = 1'b0;
   bund_t q[$];
   vec_t  tbl[5];

   imm_gen_pipe_if #(.LANES(2), .XLEN(32), .IMM_W(25)) b32 ();
   imm_gen_pipe_if #(.LANES(2), .XLEN(64), .IMM_W(25)) b64 ();

   assign b32.in_valid   = in_valid;
   assign b32.in_lane_en = lane_en;
   assign b32.imm        = imm;
   assign b32.imm_src    = src;
   assign b32.out_ready  = out_ready;
   assign b64.in_valid   = in_valid;
   assign b64.in_lane_en = lane_en;
   assign b64.imm        = imm;
   assign b64.imm_src    = src;
   assign b64.out_ready  = out_ready;

   imm_gen_pipe #(.LANES(2), .XLEN(32), .IMM_W(25)) dut32 (
      .clk(clk), .reset(reset), .flush(flush), .bus(b32.slave));
   imm_gen_pipe #(.LANES(2), .XLEN(64), .IMM_W(25)) dut64 (
      .clk(clk), .reset(reset), .flush(flush), .bus(b64.slave));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Immediate rebuilt from the instruction word with shifts and weights.
   function automatic longint lane_ref(input logic [24:0] f, input logic [2:0] s,
                                       input bit en, output bit ill);
      logic [31:0] ins;
      int          v, hi, hi20, hi25;
      ins  = {f, 7'b0};
      ill  = 1'b0;
      v    = 0;
      hi   = $signed(ins) >>> 31;
      hi20 = $signed(ins) >>> 20;
      hi25 = $signed(ins) >>> 25;
      if (!en) return 64'd0;
      case (s)
         3'd0: v = hi20;
         3'd1: v = hi25 * 32 + int'(ins[11:7]);
         3'd2: v = hi * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
         3'd3: v = int'(ins & 32'hFFFF_F000);
         3'd4: v = hi * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
         default: begin
            ill = 1'b1;
            v   = 0;
         end
      endcase
      return longint'(v);
   endfunction

   function automatic bund_t model(input logic [1:0] en, input logic [49:0] im, input logic [5:0] s);
      bund_t b;
      bit    il;
      b    = '0;
      b.en = en;
      for (int k = 0; k < 2; k++) begin
         b.x[k*64 +: 64] = lane_ref(im[k*25 +: 25], s[k*3 +: 3], en[k], il);
         b.ill[k]        = il;
      end
      return b;
   endfunction

   task automatic chk_bundle(input string tag, input bund_t e);
      chk({tag, " out_valid"}, 128'(b64.out_valid), 128'(1));
      chk({tag, " imm64"}, b64.imm_ext, e.x);
      chk({tag, " imm32"}, 128'(b32.imm_ext), 128'({e.x[95:64], e.x[31:0]}));
      chk({tag, " lane_en"}, 128'(b64.out_lane_en), 128'(e.en));
      chk({tag, " illegal64"}, 128'(b64.out_illegal), 128'(e.ill));
      chk({tag, " illegal32"}, 128'(b32.out_illegal), 128'(e.ill));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_in();
      lane_en = 2'($urandom);
      imm     = 50'({$urandom, $urandom});
      src     = 6'($urandom);
   endtask

   // Scoreboard: occupancy predicts out_valid/in_ready; queue predicts data.
   always @(negedge clk) begin
      if (mon_en) begin
         bit    rdy_m;
         bund_t e;
         rdy_m = (q.size() < 2);
         chk("mon out_valid64", 128'(b64.out_valid), 128'(q.size() > 0));
         chk("mon out_valid32", 128'(b32.out_valid), 128'(q.size() > 0));
         chk("mon in_ready64", 128'(b64.in_ready), 128'(rdy_m));
         chk("mon in_ready32", 128'(b32.in_ready), 128'(rdy_m));
         if (out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("mon imm64", b64.imm_ext, e.x);
            chk("mon imm32", 128'(b32.imm_ext), 128'({e.x[95:64], e.x[31:0]}));
            chk("mon lane_en", 128'(b64.out_lane_en), 128'(e.en));
            chk("mon illegal", 128'(b64.out_illegal), 128'(e.ill));
         end
         if (reset || flush) q.delete();
         else if (in_valid && rdy_m) q.push_back(model(lane_en, imm, src));
      end
   end

   initial begin
      bund_t a, b, c;
      bit    held, rdy;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      lane_en = '0; imm = '0; src = '0;

      // {en, {lane1,lane0} imm, {src1,src0}, {lane1,lane0} 64-bit result, ill}
      tbl[0] = '{2'b11, {25'h1FC001F, 25'h1FFE000}, {3'b001, 3'b000},
                 {64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF}, 2'b00};
      tbl[1] = '{2'b11, {25'h0002000, 25'h1FC001D}, {3'b100, 3'b010},
                 {64'h00000000_00000800, 64'hFFFFFFFF_FFFFFFFC}, 2'b00};
      tbl[2] = '{2'b11, {25'h1000000, 25'h02468A0}, {3'b011, 3'b011},
                 {64'hFFFFFFFF_80000000, 64'h00000000_12345000}, 2'b00};
      tbl[3] = '{2'b01, {25'h1ABCDEF, 25'h1ABCDEF}, {3'b111, 3'b111},
                 {64'h0, 64'h0}, 2'b01};
      tbl[4] = '{2'b01, {25'h1FFE000, 25'h0123456}, {3'b000, 3'b101},
                 {64'h0, 64'h0}, 2'b01};

      tick();
      tick();
      @(negedge clk);
      chk("reset out_valid", 128'(b64.out_valid), 128'(0));
      chk("reset in_ready", 128'(b64.in_ready), 128'(1));
      chk("reset imm64", b64.imm_ext, 128'(0));
      chk("reset imm32", 128'(b32.imm_ext), 128'(0));
      chk("reset lane_en", 128'(b64.out_lane_en), 128'(0));
      chk("reset illegal", 128'(b64.out_illegal), 128'(0));
      tick();
      reset  = 1'b0;
      mon_en = 1'b1;

      // Constant vectors, each visible one cycle after acceptance.
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         lane_en  = tbl[i].en;
         imm      = tbl[i].imm;
         src      = tbl[i].src;
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         @(negedge clk);
         chk_bundle($sformatf("vec%0d", i), '{tbl[i].en, tbl[i].x, tbl[i].ill});
         tick();
      end

      // Backpressure: A, B fill both registers, C waits.
      out_ready = 1'b0;
      rand_in(); a = model(lane_en, imm, src); in_valid = 1'b1;
      tick();
      rand_in(); b = model(lane_en, imm, src);
      tick();
      rand_in(); c = model(lane_en, imm, src);
      @(negedge clk);
      chk("bp in_ready low", 128'(b64.in_ready), 128'(0));
      chk_bundle("bp A held", a);
      tick();
      @(negedge clk);
      chk("bp in_ready still low", 128'(b64.in_ready), 128'(0));
      chk_bundle("bp A still", a);
      tick();
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      chk_bundle("bp B", b);
      chk("bp in_ready rises", 128'(b64.in_ready), 128'(1));
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk_bundle("bp C", c);
      tick();
      @(negedge clk);
      chk("bp drained", 128'(b64.out_valid), 128'(0));
      tick();

      // Flush with both registers full and an input presented.
      out_ready = 1'b0;
      rand_in(); in_valid = 1'b1;
      tick();
      rand_in();
      tick();
      rand_in(); flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush out_valid", 128'(b64.out_valid), 128'(0));
      chk("flush in_ready", 128'(b64.in_ready), 128'(1));
      tick();
      tick();
      @(negedge clk);
      chk("flush input absent", 128'(b64.out_valid), 128'(0));
      tick();

      // Flush with one entry while in_ready is high: input still dropped.
      rand_in(); in_valid = 1'b1;
      tick();
      rand_in(); flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      tick();
      @(negedge clk);
      chk("flush rdy input absent", 128'(b64.out_valid), 128'(0));
      tick();

      // Reset mid-operation with both registers full.
      rand_in(); lane_en = 2'b11; src = 6'b111_111; in_valid = 1'b1;
      tick();
      rand_in();
      tick();
      rand_in(); reset = 1'b1;
      tick();
      reset = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("rst out_valid", 128'(b64.out_valid), 128'(0));
      chk("rst in_ready", 128'(b64.in_ready), 128'(1));
      chk("rst imm64", b64.imm_ext, 128'(0));
      chk("rst imm32", 128'(b32.imm_ext), 128'(0));
      chk("rst lane_en", 128'(b64.out_lane_en), 128'(0));
      chk("rst illegal", 128'(b64.out_illegal), 128'(0));
      chk("rst illegal32", 128'(b32.out_illegal), 128'(0));
      tick();

      // Random traffic; inputs held while offered and not accepted.
      held = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (!held) begin
            in_valid = ($urandom_range(0, 3) != 0);
            rand_in();
         end
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         reset     = ($urandom_range(0, 199) == 0);
         rdy       = b64.in_ready;
         tick();
         held = in_valid && !rdy;
      end
      in_valid = 1'b0; flush = 1'b0; reset = 1'b0;
      tick();
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Multi-lane, pipelined immediate generator for the superscalar decode stage.
- Each lane takes the 25-bit immediate field (instruction bits [31:7]) and a 3-bit format select.
- Produces the sign-extended XLEN-bit immediate for all five formats, plus a per-lane illegal-format flag.
- Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so rename-stage backpressure never drops a bundle; flush squashes everything in flight.

Parameters:
- LANES, 2, number of parallel decode lanes (1..8).
- XLEN, 32, output immediate width (32 or 64); all formats sign-extend bit 31 of the 32-bit result.
- IMM_W, 25, per-lane immediate field width; fixed, holds instruction bits [31:7].

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash: drop all buffered bundles at the next edge.
- in_valid  in  1  input bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- in_lane_en  in  LANES  per-lane valid within the bundle.
- imm  in  LANES*IMM_W  lane k immediate field at [k*25 +: 25]; imm[i] = instr[i+7].
- imm_src  in  LANES*3  lane k format select at [k*3 +: 3].
- out_valid  out  1  output bundle valid.
- out_ready  in  1  consumer accepts the bundle.
- out_lane_en  out  LANES  registered copy of in_lane_en.
- imm_ext  out  LANES*XLEN  lane k immediate at [k*XLEN +: XLEN].
- out_illegal  out  LANES  lane enabled with an unsupported imm_src.

Behaviour:
- Format encoding (32-bit result r, then sign-extend r[31] to XLEN):
  - 000 I: r = sext(imm[24:13]).
  - 001 S: r = sext({imm[24:18], imm[4:0]}).
  - 010 B: r = sext({imm[24], imm[0], imm[23:18], imm[4:1], 1'b0}).
  - 011 U: r = {imm[24:5], 12'b0}.
  - 100 J: r = sext({imm[24], imm[12:5], imm[13], imm[23:14], 1'b0}).
  - 101/110/111: r = 0 and out_illegal[k] = 1.
- Disabled lane (in_lane_en[k] = 0): imm_ext lane = 0, out_illegal[k] = 0, regardless of imm_src.
- Decode is combinational on the inputs; results are captured into the main register or the skid register. No logic sits between those registers and the outputs.
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Latency: 1 cycle. A bundle accepted at edge N is presented at out_valid after edge N when the main register is free or draining.
- Skid buffer: main register (drives outputs) plus one skid register.
  - in_ready = !skid_valid, registered.
  - Input accepted while main is valid and not draining: the bundle goes to skid; in_ready falls next cycle.
  - Output transfer with skid valid: skid moves to main, and in_ready rises next cycle.
  - Output transfer with skid empty and an input transfer: the new bundle goes directly to main.
  - Order is strictly preserved; no bundle is duplicated or lost.
- Full: both registers valid means in_ready = 0; in_valid is ignored.
- Empty: out_valid = 0. imm_ext / out_lane_en / out_illegal hold the last values and must not be relied on.
- Flush:
  - At the next edge, main_valid = skid_valid = 0 and in_ready = 1.
  - An input presented in the flush cycle is discarded, even if in_ready = 1.
  - An output transfer in the flush cycle counts as consumed.
  - Flush has priority over every other event.
- Reset (including mid-operation) behaves like flush, and additionally sets out_valid = 0, in_ready = 1, imm_ext = 0, out_lane_en = 0, out_illegal = 0.
- Inputs must be held stable while in_valid = 1 and in_ready = 0 (no acceptance is taken).

Test Plan:
- I/S sign extension, XLEN=32:
  - lane0 src 000, imm[24:13] = 0xFFF -> 0xFFFFFFFF.
  - lane1 src 001, imm[24:18] = 0x7F, imm[4:0] = 0x1F -> 0xFFFFFFFF.
  - Both visible one cycle after acceptance.
- B/J offsets:
  - src 010 with imm[24] = 1, imm[23:18] = 0x3F, imm[4:1] = 0xE, imm[0] = 1 -> 0xFFFFFFFC.
  - src 100 with only imm[13] = 1 -> 0x00000800.
- U and XLEN=64:
  - src 011, imm[24:5] = 0x12345 -> 0x0000000012345000.
  - imm[24:5] = 0x80000 -> 0xFFFFFFFF80000000.
- Illegal/disabled lanes:
  - src 111 on an enabled lane -> imm 0, out_illegal = 1.
  - src 111 on a disabled lane -> imm 0, out_illegal = 0.
- Backpressure:
  - Hold out_ready = 0 and drive 3 consecutive bundles A, B, C.
  - Required: A and B accepted, in_ready = 0 from the cycle after B.
  - Release out_ready: outputs A, B, C in order, no gaps once C is accepted.
- Flush/reset:
  - With both registers full, assert flush while in_valid = 1.
  - Required: next cycle out_valid = 0, in_ready = 1, flush-cycle input absent.
  - Repeat with reset: all outputs zero.
